// File: rtl/serial_sum_deserializer.sv
// ---------------------------------------------------------------------------
// serial_sum_deserializer
//
// Receive end of the bit-serial arithmetic datapath. Sum bits arrive LSB
// first from the serial adder, one per bit_valid cycle. They are collected
// into a WIDTH-bit parallel word, and the adder's final carry is captured
// alongside the last bit. Completed words are offered downstream on a
// valid/ready port. A one-deep holding register lets the next frame shift
// in while the previous word waits to be accepted.
//
// Parameters
//   WIDTH       bits per frame and output word width (>= 2)
//
// Ports
//   clk         single clock, all logic on the rising edge
//   rst_n       synchronous reset, active low
//   bit_in      serial sum bit, LSB first
//   carry_in    adder carry, sampled only together with the last bit
//   bit_valid   bit_in/carry_in valid this cycle; stall gaps are allowed
//   bit_first   marks bit_in as bit 0 of a new frame (with bit_valid)
//   word_out    assembled word, bit i = i-th received bit
//   carry_flag  carry captured with the last bit of the held word
//   word_valid  word_out/carry_flag hold a completed word
//   word_ready  downstream takes the word when word_valid & word_ready
//   busy        a frame is being shifted in
//   overrun     one-cycle pulse: a completed frame was dropped (holding full)
//   frame_err   one-cycle pulse: bit_first arrived in the middle of a frame
// ---------------------------------------------------------------------------
module serial_sum_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             carry_in,
  input  logic             bit_valid,
  input  logic             bit_first,
  output logic [WIDTH-1:0] word_out,
  output logic             carry_flag,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  // The counter only ever has to name positions 0..WIDTH-1.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  // Shift side state. The shift register holds only bits 0..WIDTH-2: the
  // top bit arrives on the completing cycle and goes straight into the
  // holding register, so it never needs its own storage.
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-2:0]  shift_q, shift_d;
  logic              frame_err_q, frame_err_d;

  // Output side state: the one-deep holding register and its flags.
  logic [WIDTH-1:0]  word_q, word_d;
  logic              carry_q, carry_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  // Handshake between the two halves for the completing cycle.
  logic              frame_done;
  logic [WIDTH-1:0]  frame_word;

  // Shift-side next state. IDLE waits for a bit_first to open a frame;
  // SHIFT drops each valid bit into the position named by the counter.
  // A bit_first seen while already shifting (including on what would have
  // been the last bit) abandons the partial frame and restarts from bit 0,
  // flagging frame_err. On the true last bit the frame is handed over to
  // the output side in the same cycle and the FSM returns to IDLE, so bit 0
  // of a following frame can be taken on the very next cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    frame_done  = 1'b0;
    frame_word  = {bit_in, shift_q};

    case (state_q)
      IDLE: begin
        if (bit_valid && bit_first) begin
          shift_d    = '0;
          shift_d[0] = bit_in;
          cnt_d      = CNT_ONE;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_valid) begin
          if (bit_first) begin
            frame_err_d = 1'b1;
            shift_d     = '0;
            shift_d[0]  = bit_in;
            cnt_d       = CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            frame_done = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            shift_d[cnt_q] = bit_in;
            cnt_d          = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output-side next state. A completed frame loads when the holding
  // register is empty or is being emptied on this same edge; otherwise the
  // new frame is dropped, the held word is left untouched and overrun
  // pulses. With no frame completing, an accepted word simply clears the
  // valid flag. The held word and carry never change while waiting.
  always_comb begin
    word_d    = word_q;
    carry_d   = carry_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (frame_done) begin
      if (!valid_q || word_ready) begin
        word_d  = frame_word;
        carry_d = carry_in;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  // All state registers. Reset clears both halves, discarding any partial
  // frame and any word still waiting in the holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      word_q      <= '0;
      carry_q     <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      word_q      <= word_d;
      carry_q     <= carry_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign word_out   = word_q;
  assign carry_flag = carry_q;
  assign word_valid = valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == SHIFT);

endmodule
